// File: rtl/ic_dma_reader.sv
// ic_dma_reader: instruction-cache line-fill engine.
// Takes one line request from the I-cache FSM, issues BEATS narrow reads on
// the memory read port, reassembles the returned beats into a line and
// returns it with a one-cycle acknowledge (optionally flagged as a timeout).
//
// Handshakes:
//   ic_read_dma_valid/ack : valid is held by the requester until ack; ack is a
//     single-cycle pulse with data/err stable; valid must drop the cycle after
//     ack, because any valid seen in IDLE starts a new request.
//   mem_rd_req/gnt        : req and addr are registered and held until a cycle
//     with req=1 and gnt=1, which transfers that beat address.
//   mem_rd_valid/data     : one data beat per valid cycle, in request order, no
//     back-pressure.
module ic_dma_reader #(
    parameter int ADDR_W  = 33,
    parameter int LINE_W  = 128,
    parameter int MEM_DW  = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ic_read_dma_valid,
    input  logic [ADDR_W-1:0] ic_read_dma_addr,
    output logic              ic_read_dma_ack,
    output logic [LINE_W-1:0] ic_read_dma_data,
    output logic              ic_read_dma_err,
    output logic              mem_rd_req,
    output logic [ADDR_W-1:0] mem_rd_addr,
    input  logic              mem_rd_gnt,
    input  logic              mem_rd_valid,
    input  logic [MEM_DW-1:0] mem_rd_data,
    output logic [1:0]        dbg_state
);

    localparam int BEATS      = LINE_W / MEM_DW;
    localparam int LOG_B      = $clog2(BEATS);
    localparam int CNT_W      = LOG_B + 1;
    localparam int OFF_W      = $clog2(LINE_W / 8);
    localparam int BEAT_SHIFT = $clog2(MEM_DW / 8);
    localparam int TO_W       = $clog2(TIMEOUT + 1);

    localparam logic [CNT_W-1:0] BEATS_C   = CNT_W'(BEATS);
    localparam logic [CNT_W-1:0] LAST_C    = CNT_W'(BEATS - 1);
    localparam logic [TO_W-1:0]  TIMEOUT_C = TO_W'(TIMEOUT);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]        state_q;
    logic [ADDR_W-1:0] base_q;
    logic [CNT_W-1:0]  acnt_q;
    logic [CNT_W-1:0]  dcnt_q;
    logic [TO_W-1:0]   tcnt_q;
    logic [LINE_W-1:0] line_q;
    logic              req_q;
    logic [ADDR_W-1:0] addr_q;
    logic              ack_q;
    logic              err_q;

    logic              busy;
    logic              accept;
    logic              addr_fire;
    logic              beat_fire;
    logic              last_beat;
    logic              timeout_hit;
    logic [CNT_W-1:0]  acnt_inc;
    logic [TO_W-1:0]   tcnt_inc;
    logic [ADDR_W-1:0] next_addr;
    logic [ADDR_W-1:0] accept_base;

    // The byte offset inside the line is deliberately discarded.
    logic unused_addr_bits;
    assign unused_addr_bits = ^ic_read_dma_addr[OFF_W-1:0];

    // Per-cycle event decode for the address side, data side and watchdog.
    always_comb begin
        busy        = (state_q == S_BUSY);
        accept      = (state_q == S_IDLE) && ic_read_dma_valid;
        addr_fire   = busy && req_q && mem_rd_gnt;
        beat_fire   = busy && mem_rd_valid;
        last_beat   = beat_fire && (dcnt_q == LAST_C);
        acnt_inc    = acnt_q + 1'b1;
        // Saturating increment so the counter can never wrap back to zero.
        tcnt_inc    = (tcnt_q == TIMEOUT_C) ? tcnt_q : tcnt_q + 1'b1;
        timeout_hit = busy && !mem_rd_valid && (tcnt_inc == TIMEOUT_C);
        next_addr   = base_q + (ADDR_W'(acnt_inc) << BEAT_SHIFT);
        accept_base = {ic_read_dma_addr[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
    end

    // Control FSM: request acceptance, beat address issue, counters, ack/err.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            base_q  <= '0;
            acnt_q  <= '0;
            dcnt_q  <= '0;
            tcnt_q  <= '0;
            req_q   <= 1'b0;
            addr_q  <= '0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (accept) begin
                        base_q  <= accept_base;
                        acnt_q  <= '0;
                        dcnt_q  <= '0;
                        tcnt_q  <= '0;
                        req_q   <= 1'b1;
                        addr_q  <= accept_base;
                        state_q <= S_BUSY;
                    end
                end
                S_BUSY: begin
                    // Address side: advance on each accepted beat address.
                    if (addr_fire) begin
                        acnt_q <= acnt_inc;
                        if (acnt_inc < BEATS_C) begin
                            addr_q <= next_addr;
                        end else begin
                            req_q <= 1'b0;
                        end
                    end
                    // Data side and inter-beat watchdog.
                    if (beat_fire) begin
                        dcnt_q <= dcnt_q + 1'b1;
                        tcnt_q <= '0;
                    end else begin
                        tcnt_q <= tcnt_inc;
                    end
                    if (last_beat) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b0;
                        req_q   <= 1'b0;
                    end else if (timeout_hit) begin
                        state_q <= S_DONE;
                        ack_q   <= 1'b1;
                        err_q   <= 1'b1;
                        req_q   <= 1'b0;
                    end
                end
                S_DONE: begin
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= 1'b0;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                end
            endcase
        end
    end

    // Line buffer: cleared on acceptance, beat k lands at bits [k*MEM_DW +: MEM_DW].
    always_ff @(posedge clk) begin
        if (rst) begin
            line_q <= '0;
        end else if (accept) begin
            line_q <= '0;
        end else if (beat_fire) begin
            for (int b = 0; b < BEATS; b++) begin
                if (dcnt_q[LOG_B-1:0] == LOG_B'(b)) begin
                    line_q[b*MEM_DW +: MEM_DW] <= mem_rd_data;
                end
            end
        end
    end

    assign ic_read_dma_ack  = ack_q;
    assign ic_read_dma_err  = err_q;
    assign ic_read_dma_data = line_q;
    assign mem_rd_req       = req_q;
    assign mem_rd_addr      = addr_q;
    assign dbg_state        = state_q;

endmodule

// File: tb/tb_ic_dma_reader.sv
// Self-checking bench for ic_dma_reader: directed scenarios plus randomized
// fills, with a memory-side responder and a line/address reference model.
module tb_ic_dma_reader;

    localparam int ADDR_W  = 33;
    localparam int LINE_W  = 128;
    localparam int MEM_DW  = 32;
    localparam int TIMEOUT = 16;
    localparam int BEATS   = LINE_W / MEM_DW;

    logic              clk = 1'b0;
    logic              rst;
    logic              ic_read_dma_valid;
    logic [ADDR_W-1:0] ic_read_dma_addr;
    logic              ic_read_dma_ack;
    logic [LINE_W-1:0] ic_read_dma_data;
    logic              ic_read_dma_err;
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_gnt;
    logic              mem_rd_valid;
    logic [MEM_DW-1:0] mem_rd_data;
    logic [1:0]        dbg_state;

    int vectors     = 0;
    int miscompares = 0;

    logic [ADDR_W-1:0] exp_q[$];
    int                due_q[$];

    always #5 clk = ~clk;

    ic_dma_reader #(
        .ADDR_W (ADDR_W),
        .LINE_W (LINE_W),
        .MEM_DW (MEM_DW),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .ic_read_dma_valid(ic_read_dma_valid),
        .ic_read_dma_addr (ic_read_dma_addr),
        .ic_read_dma_ack  (ic_read_dma_ack),
        .ic_read_dma_data (ic_read_dma_data),
        .ic_read_dma_err  (ic_read_dma_err),
        .mem_rd_req       (mem_rd_req),
        .mem_rd_addr      (mem_rd_addr),
        .mem_rd_gnt       (mem_rd_gnt),
        .mem_rd_valid     (mem_rd_valid),
        .mem_rd_data      (mem_rd_data),
        .dbg_state        (dbg_state)
    );

    task automatic check(input string tag, input logic [LINE_W-1:0] obs, input logic [LINE_W-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one line request and act as the memory until ack (or budget runs out).
    task automatic run_line(input logic [ADDR_W-1:0] addr, input int lat, input int gap_max,
                            input int stall_beat, input int stall_len, input int nret,
                            input bit gnt_rand, input bit fixed_data,
                            output int ack_c, output int last_c, output logic [LINE_W-1:0] line_out);
        logic [ADDR_W-1:0] base;
        logic [LINE_W-1:0] exp_line;
        int c, ngrant, nbeat, stall_rem, last_due, due, gap;
        bit done;
        base = {addr[ADDR_W-1:4], 4'h0};
        exp_q.delete();
        due_q.delete();
        for (int k = 0; k < BEATS; k++) exp_q.push_back(base + ADDR_W'(4 * k));
        exp_line  = '0;
        c         = 0;
        ngrant    = 0;
        nbeat     = 0;
        stall_rem = stall_len;
        last_due  = -1;
        ack_c     = -1;
        last_c    = -1;
        line_out  = '0;
        done      = 1'b0;
        ic_read_dma_valid = 1'b1;
        ic_read_dma_addr  = addr;
        mem_rd_gnt        = 1'b0;
        mem_rd_valid      = 1'b0;
        while (!done && c < 300) begin
            tick();
            c++;
            if (c == 1) check("req_first_cycle", mem_rd_req, 1);
            if (ic_read_dma_ack) begin
                ack_c        = c;
                mem_rd_gnt   = 1'b0;
                mem_rd_valid = 1'b0;
                check("ack_err", ic_read_dma_err, (nret < BEATS));
                check("ack_data", ic_read_dma_data, exp_line);
                line_out = ic_read_dma_data;
                done     = 1'b1;
            end else begin
                mem_rd_gnt = 1'b0;
                if (mem_rd_req) begin
                    if (ngrant == stall_beat && stall_rem > 0) begin
                        if (exp_q.size() > 0) check("stall_addr_hold", mem_rd_addr, exp_q[0]);
                        stall_rem--;
                    end else if (!gnt_rand || $urandom_range(0, 3) != 0) begin
                        mem_rd_gnt = 1'b1;
                    end
                    if (mem_rd_gnt) begin
                        check("grant_in_range", (ngrant < BEATS), 1);
                        if (exp_q.size() > 0) check("beat_addr", mem_rd_addr, exp_q.pop_front());
                        ngrant++;
                        if (ngrant <= nret) begin
                            due = c + lat;
                            gap = (last_due < 0) ? 0 : $urandom_range(0, gap_max);
                            if (last_due >= 0 && due < last_due + 1 + gap) due = last_due + 1 + gap;
                            last_due = due;
                            due_q.push_back(due);
                        end
                    end
                end
                mem_rd_valid = 1'b0;
                mem_rd_data  = $urandom();
                if (due_q.size() > 0 && due_q[0] == c) begin
                    mem_rd_valid = 1'b1;
                    if (fixed_data) mem_rd_data = MEM_DW'(32'h11 * (nbeat + 1));
                    if (nbeat < BEATS) exp_line[nbeat*MEM_DW +: MEM_DW] = mem_rd_data;
                    nbeat++;
                    last_c = c;
                    void'(due_q.pop_front());
                end
            end
        end
        check("ack_seen", done, 1);
    endtask

    // Cycle after ack: ack gone, back in IDLE, line held; optionally present the next request.
    task automatic post_ack(input bit next_valid, input logic [ADDR_W-1:0] next_addr,
                            input logic [LINE_W-1:0] held);
        tick();
        mem_rd_gnt   = 1'b0;
        mem_rd_valid = 1'b0;
        check("ack_single_pulse", ic_read_dma_ack, 0);
        check("idle_after_done", dbg_state, 2'd0);
        check("data_held", ic_read_dma_data, held);
        check("req_low_after", mem_rd_req, 0);
        ic_read_dma_valid = next_valid;
        ic_read_dma_addr  = next_addr;
    endtask

    initial begin
        int ack_c, last_c;
        logic [LINE_W-1:0] line;
        logic [ADDR_W-1:0] raddr;

        // Reset
        rst               = 1'b1;
        ic_read_dma_valid = 1'b0;
        ic_read_dma_addr  = '0;
        mem_rd_gnt        = 1'b0;
        mem_rd_valid      = 1'b0;
        mem_rd_data       = '0;
        tick();
        tick();
        check("rst_ack", ic_read_dma_ack, 0);
        check("rst_err", ic_read_dma_err, 0);
        check("rst_data", ic_read_dma_data, 0);
        check("rst_req", mem_rd_req, 0);
        check("rst_addr", mem_rd_addr, 0);
        check("rst_state", dbg_state, 2'd0);
        rst = 1'b0;
        tick();

        // Basic fill with minimum latency and fixed data.
        run_line(33'h0_0000_0013, 1, 0, -1, 0, 4, 1'b0, 1'b1, ack_c, last_c, line);
        check("basic_ack_cycle", ack_c, 6);
        check("basic_line", line, 128'h00000044_00000033_00000022_00000011);
        post_ack(1'b0, '0, line);

        // Grant withheld for 5 cycles on beat 2.
        raddr = ADDR_W'({$urandom(), $urandom()});
        run_line(raddr, 1, 0, 2, 5, 4, 1'b0, 1'b0, ack_c, last_c, line);
        check("stall_ack_cycle", ack_c, 11);
        post_ack(1'b0, '0, line);

        // Overlap: beat 0 data coincides with the grant of beat 3, then 0-3 cycle gaps.
        raddr = ADDR_W'({$urandom(), $urandom()});
        run_line(raddr, 3, 3, -1, 0, 4, 1'b0, 1'b0, ack_c, last_c, line);
        post_ack(1'b0, '0, line);

        // Timeout: only two beats come back.
        raddr = ADDR_W'({$urandom(), $urandom()});
        run_line(raddr, 1, 0, -1, 0, 2, 1'b0, 1'b0, ack_c, last_c, line);
        check("timeout_idle_span", ack_c - last_c, TIMEOUT + 1);
        check("timeout_upper_zero", line[LINE_W-1:64], 0);
        post_ack(1'b0, '0, line);
        run_line(33'h0_0000_1000, 1, 1, -1, 0, 4, 1'b0, 1'b0, ack_c, last_c, line);
        post_ack(1'b0, '0, line);

        // Reset for one cycle after two grants.
        ic_read_dma_valid = 1'b1;
        ic_read_dma_addr  = 33'h1_2345_6788;
        mem_rd_gnt        = 1'b1;
        tick();
        check("pre_rst_addr0", mem_rd_addr, 33'h1_2345_6780);
        tick();
        check("pre_rst_addr1", mem_rd_addr, 33'h1_2345_6784);
        tick();
        rst               = 1'b1;
        mem_rd_gnt        = 1'b0;
        ic_read_dma_valid = 1'b0;
        tick();
        check("midrst_req", mem_rd_req, 0);
        check("midrst_ack", ic_read_dma_ack, 0);
        check("midrst_state", dbg_state, 2'd0);
        rst = 1'b0;
        run_line(33'h0_0000_0044, 1, 0, -1, 0, 4, 1'b0, 1'b0, ack_c, last_c, line);
        check("after_rst_ack_cycle", ack_c, 6);

        // Back-to-back: new request presented in the cycle right after ack.
        post_ack(1'b1, 33'h0_0000_0020, line);
        run_line(33'h0_0000_0020, 1, 0, -1, 0, 4, 1'b0, 1'b0, ack_c, last_c, line);
        post_ack(1'b0, '0, line);

        // Randomized fills, including addresses near the top of the space.
        for (int i = 0; i < 6; i++) begin
            raddr = ADDR_W'({$urandom(), $urandom()});
            if (i == 0) raddr = 33'h1_FFFF_FFF7;
            run_line(raddr, $urandom_range(1, 3), 3, $urandom_range(0, 3), $urandom_range(0, 4),
                     4, 1'b1, 1'b0, ack_c, last_c, line);
            post_ack(1'b0, '0, line);
            repeat ($urandom_range(0, 2)) tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
